ifetch_stage: RTL
=================

Name: ifetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC register and PC+4 adder.
- Accepts a PC, issues one instruction-memory read and waits for the response (variable latency).
- Presents {instruction, PC, PC+4, fault code} to decode through a valid/ready handshake.
- Back-pressures the PC register through fetch_ready; supports pipeline flush and flags misaligned PCs and memory timeouts.

Parameters:
- TIMEOUT, 16: maximum cycles spent in WAIT without imem_rvalid before a timeout fault; legal range 1..255.
- NOP_INSTR, 32'h00000000: value driven on instr at reset and on any faulted fetch.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  PC from the PC register.
- pc_valid  in  1  pc is valid this cycle.
- fetch_ready  out  1  stage accepts pc this cycle; the PC register must hold when low.
- flush  in  1  discard the in-flight and held fetch.
- imem_req  out  1  one-cycle read strobe to instruction memory.
- imem_addr  out  32  read address, stable throughout WAIT.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- instr_valid  out  1  decode output valid.
- instr  out  32  fetched instruction.
- instr_pc  out  32  PC of instr.
- instr_pcplus4  out  32  instr_pc + 4, modulo 2^32.
- instr_fault  out  2  00 none, 01 misaligned, 10 timeout.
- decode_ready  in  1  decode consumes the output this cycle.

Behaviour:
- Reset values:
  - state IDLE, fetch_ready=1, imem_req=0, imem_addr=0.
  - instr_valid=0, instr=NOP_INSTR, instr_pc=0, instr_pcplus4=4, instr_fault=00.
  - drop flag=0, timeout counter=0.
- Reset overrides every other input in the same cycle, including mid-WAIT; a later stray imem_rvalid is ignored.
- fetch_ready is combinational: (state==IDLE) | (state==OUT & decode_ready), forced to 0 when flush=1.
- Accept event: fetch_ready & pc_valid at a clock edge.
- States:
  - IDLE:
    - Accept with pc[1:0]==00: latch pc, assert imem_req=1 and imem_addr=pc next cycle, go to WAIT, clear the counter.
    - Accept with pc[1:0]!=00: no memory access; go to OUT with fault 01, instr=NOP_INSTR, instr_pc=pc.
  - WAIT:
    - imem_req is high only in the first WAIT cycle.
    - imem_rvalid is sampled every WAIT cycle, including the imem_req cycle.
    - On rvalid with drop=0: instr<=imem_rdata, fault 00, go to OUT.
    - On rvalid with drop=1: clear drop, go to IDLE, no output.
    - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without rvalid: go to OUT with fault 10 and instr=NOP_INSTR, or to IDLE if drop=1.
    - flush in WAIT sets drop=1; the state stays WAIT until the response or timeout.
  - OUT:
    - instr_valid=1; outputs stay stable while decode_ready=0.
    - decode_ready=1 with an accept: back-to-back. Same transitions as IDLE, and instr_valid drops the next cycle.
    - decode_ready=1 without an accept: go to IDLE.
    - flush: go to IDLE; instr_valid=0 next cycle; no accept that cycle.
- imem_rvalid outside WAIT is ignored.
- flush in IDLE blocks acceptance for that cycle only.
- Latency: accept at edge N. With a zero-wait memory (rvalid in the imem_req cycle), instr_valid=1 from cycle N+2. Throughput is one instruction per 2 cycles at best.
- instr_pcplus4 wraps: for pc=32'hFFFFFFFC it is 32'h00000000.
- instr_fault is meaningful only while instr_valid=1.

Test Plan:
1. Reset, then pc=32'h00000000 with pc_valid and decode_ready held high; memory returns 32'h20080005 in the imem_req cycle -> imem_req pulses at cycle 1 with imem_addr=0; instr_valid at cycle 2 with instr=32'h20080005, instr_pcplus4=32'h4, fault 00.
2. Memory returns data 3 cycles after imem_req and decode_ready is low for 4 cycles -> outputs held stable, fetch_ready=0 throughout; the next pc is accepted on the cycle decode_ready rises.
3. pc=32'h00000006 -> no imem_req; instr_valid with fault 01, instr=NOP_INSTR, instr_pc=32'h6.
4. flush asserted one cycle after imem_req, response 2 cycles later -> response discarded, no instr_valid, state IDLE; the next pc fetches normally.
5. TIMEOUT=16 with no rvalid -> fault 10 in the cycle after the 16th WAIT cycle; a late rvalid is ignored. Also, pc=32'hFFFFFFFC -> instr_pcplus4=0.
6. reset asserted mid-WAIT -> all outputs at reset values next cycle; a subsequent rvalid produces no instr_valid.

Source files
------------

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: takes a PC, performs one variable-latency imem read and
// hands {instr, pc, pc+4, fault} to decode over a valid/ready handshake.
module ifetch_stage #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        fetch_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcplus4,
  output logic [1:0]  instr_fault,
  input  logic        decode_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       drop;
  logic       accept;
  logic       aligned;
  logic       kill;
  logic       resp_done;

  // Handshake decode and next-state selection
  always_comb begin
    fetch_ready = 1'b0;
    state_next  = state;
    if (flush) begin
      fetch_ready = 1'b0;
    end else if (state == S_IDLE) begin
      fetch_ready = 1'b1;
    end else if ((state == S_OUT) && decode_ready) begin
      fetch_ready = 1'b1;
    end else begin
      fetch_ready = 1'b0;
    end
    accept    = fetch_ready & pc_valid;
    aligned   = (pc[1:0] == 2'b00);
    // A flush arriving together with the response still discards it
    kill      = drop | flush;
    resp_done = imem_rvalid | (wait_cnt == LAST_CNT);
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = aligned ? S_WAIT : S_OUT;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (resp_done) begin
          state_next = kill ? S_IDLE : S_OUT;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_OUT: begin
        if (flush) begin
          state_next = S_IDLE;
        end else if (accept) begin
          state_next = aligned ? S_WAIT : S_OUT;
        end else if (decode_ready) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_OUT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request, timeout tracking and decode-facing output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_req      <= 1'b0;
      imem_addr     <= 32'h00000000;
      instr_valid   <= 1'b0;
      instr         <= NOP_INSTR;
      instr_pc      <= 32'h00000000;
      instr_pcplus4 <= 32'h00000004;
      instr_fault   <= 2'b00;
      drop          <= 1'b0;
      wait_cnt      <= 8'd0;
    end else begin
      imem_req    <= accept & aligned;
      instr_valid <= (state_next == S_OUT);
      if (accept) begin
        instr_pc      <= pc;
        instr_pcplus4 <= pc + 32'd4;
        if (aligned) begin
          imem_addr <= pc;
          wait_cnt  <= 8'd0;
          drop      <= 1'b0;
        end else begin
          instr       <= NOP_INSTR;
          instr_fault <= 2'b01;
        end
      end
      if (state == S_WAIT) begin
        if (resp_done) begin
          drop <= 1'b0;
          if (!kill) begin
            instr       <= imem_rvalid ? imem_rdata : NOP_INSTR;
            instr_fault <= imem_rvalid ? 2'b00 : 2'b10;
          end
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
          if (flush) begin
            drop <= 1'b1;
          end
        end
      end
    end
  end

endmodule
